// File: rtl/riscv_halt_ctrl.sv
// Halt controller for a simple in-order RISC-V pipeline: watches the MEM_WB
// stage, stalls fetch on a halt trigger, drains the pipe and then stops.
module riscv_halt_ctrl #(
  parameter int OPCODE_WIDTH   = 7,
  parameter int CNT_WIDTH      = 32,
  parameter int DRAIN_CYCLES   = 3,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    wb_valid,
  input  logic [OPCODE_WIDTH-1:0] wb_opcode,
  input  logic                    ext_halt,
  output logic                    pc_stall,
  output logic                    halted,
  output logic [1:0]              halt_cause,
  output logic [CNT_WIDTH-1:0]    cycle_cnt,
  output logic [CNT_WIDTH-1:0]    retire_cnt
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_INVALID = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
  localparam logic [1:0] CAUSE_EXT     = 2'b11;

  localparam int DW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // A limit the counter can never reach (it saturates first) disables the timeout.
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0) &&
                         ((CNT_WIDTH >= 31) || ((TIMEOUT_CYCLES - 1) < (1 << CNT_WIDTH)));
  localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  localparam logic [OPCODE_WIDTH-1:0] OP_OP     = OPCODE_WIDTH'(7'b0110011);
  localparam logic [OPCODE_WIDTH-1:0] OP_IMM    = OPCODE_WIDTH'(7'b0010011);
  localparam logic [OPCODE_WIDTH-1:0] OP_LOAD   = OPCODE_WIDTH'(7'b0000011);
  localparam logic [OPCODE_WIDTH-1:0] OP_STORE  = OPCODE_WIDTH'(7'b0100011);
  localparam logic [OPCODE_WIDTH-1:0] OP_BRANCH = OPCODE_WIDTH'(7'b1100011);
  localparam logic [OPCODE_WIDTH-1:0] OP_JAL    = OPCODE_WIDTH'(7'b1101111);
  localparam logic [OPCODE_WIDTH-1:0] OP_JALR   = OPCODE_WIDTH'(7'b1100111);
  localparam logic [OPCODE_WIDTH-1:0] OP_LUI    = OPCODE_WIDTH'(7'b0110111);
  localparam logic [OPCODE_WIDTH-1:0] OP_AUIPC  = OPCODE_WIDTH'(7'b0010111);
  localparam logic [OPCODE_WIDTH-1:0] OP_SYSTEM = OPCODE_WIDTH'(7'b1110011);

  logic [1:0]    state;
  logic [DW-1:0] drain_cnt;
  logic          op_valid;
  logic          trig_inv;
  logic          trig_to;
  logic          trig_any;
  logic [1:0]    trig_cause;
  logic          counting;

  // NOTE: case items match exactly, so an X/Z opcode hits no item and lands in
  // default; op_valid is also assigned up front so no latch can be inferred.
  always_comb begin
    op_valid = 1'b0;
    case (wb_opcode)
      OP_OP, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM: op_valid = 1'b1;
      default:                                     op_valid = 1'b0;
    endcase
  end

  assign trig_inv = wb_valid && !op_valid;
  assign trig_to  = TO_EN && (cycle_cnt == TO_LAST);
  assign trig_any = ext_halt || trig_inv || trig_to;
  assign counting = (state != ST_HALTED);

  always_comb begin
    trig_cause = CAUSE_NONE;
    if (ext_halt)      trig_cause = CAUSE_EXT;
    else if (trig_inv) trig_cause = CAUSE_INVALID;
    else if (trig_to)  trig_cause = CAUSE_TIMEOUT;
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_RUN;
      drain_cnt  <= '0;
      pc_stall   <= 1'b0;
      halted     <= 1'b0;
      halt_cause <= CAUSE_NONE;
      cycle_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      // Counters saturate rather than wrap so a long run never looks short.
      if (counting && (cycle_cnt != CNT_MAX))
        cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
      if (counting && wb_valid && op_valid && (retire_cnt != CNT_MAX))
        retire_cnt <= retire_cnt + CNT_WIDTH'(1);

      case (state)
        ST_RUN: begin
          if (trig_any) begin
            pc_stall   <= 1'b1;
            halt_cause <= trig_cause;
            if (DRAIN_CYCLES == 0) begin
              state  <= ST_HALTED;
              halted <= 1'b1;
            end else begin
              state     <= ST_DRAIN;
              drain_cnt <= DRAIN_LOAD;
            end
          end
        end
        ST_DRAIN: begin
          drain_cnt <= drain_cnt - DW'(1);
          if (drain_cnt == DW'(1)) begin
            state  <= ST_HALTED;
            halted <= 1'b1;
          end
        end
        ST_HALTED: ;
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_halt_ctrl.sv
// Randomised and directed bench for riscv_halt_ctrl; three instances cover the
// default, zero-drain and narrow-counter configurations against one model.
module tb_riscv_halt_ctrl;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n     [N];
  logic       wb_valid  [N];
  logic [6:0] wb_opcode [N];
  logic       ext_halt  [N];
  logic       pc_stall  [N];
  logic       halted    [N];
  logic [1:0] cause     [N];
  logic [31:0] cyc0, ret0, cyc1, ret1;
  logic [3:0]  cyc2, ret2;

  int passed = 0;
  int total  = 0;

  logic [6:0] valid_ops [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011};

  riscv_halt_ctrl u_dut0 (
    .clk(clk), .reset_n(rst_n[0]), .wb_valid(wb_valid[0]), .wb_opcode(wb_opcode[0]),
    .ext_halt(ext_halt[0]), .pc_stall(pc_stall[0]), .halted(halted[0]),
    .halt_cause(cause[0]), .cycle_cnt(cyc0), .retire_cnt(ret0));

  riscv_halt_ctrl #(.DRAIN_CYCLES(0), .TIMEOUT_CYCLES(0)) u_dut1 (
    .clk(clk), .reset_n(rst_n[1]), .wb_valid(wb_valid[1]), .wb_opcode(wb_opcode[1]),
    .ext_halt(ext_halt[1]), .pc_stall(pc_stall[1]), .halted(halted[1]),
    .halt_cause(cause[1]), .cycle_cnt(cyc1), .retire_cnt(ret1));

  riscv_halt_ctrl #(.CNT_WIDTH(4), .TIMEOUT_CYCLES(0)) u_dut2 (
    .clk(clk), .reset_n(rst_n[2]), .wb_valid(wb_valid[2]), .wb_opcode(wb_opcode[2]),
    .ext_halt(ext_halt[2]), .pc_stall(pc_stall[2]), .halted(halted[2]),
    .halt_cause(cause[2]), .cycle_cnt(cyc2), .retire_cnt(ret2));

  // Reference model: remembers the edge count since reset, the edge of the
  // first trigger and the number of good retirements; outputs follow from those.
  longint     m_edges [N];
  longint     m_trig  [N];
  longint     m_ret   [N];
  logic [1:0] m_cause [N];

  function automatic int drain_of(int i);
    return (i == 1) ? 0 : 3;
  endfunction

  function automatic int tout_of(int i);
    return (i == 0) ? 200 : 0;
  endfunction

  function automatic longint sat(int i, longint x);
    longint mx = (i == 2) ? 64'd15 : 64'hFFFF_FFFF;
    return (x > mx) ? mx : x;
  endfunction

  function automatic bit op_ok(logic [6:0] op);
    return (op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                       7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011}) === 1'b1;
  endfunction

  task automatic model_reset(int i);
    m_edges[i] = 0;
    m_trig[i]  = -1;
    m_ret[i]   = 0;
    m_cause[i] = 2'b00;
  endtask

  task automatic model_step(int i);
    longint e;
    bit ok, inv, to;
    m_edges[i] = m_edges[i] + 1;
    e = m_edges[i];
    if (m_trig[i] < 0 || e <= m_trig[i] + drain_of(i)) begin
      ok = op_ok(wb_opcode[i]);
      if (wb_valid[i] && ok) m_ret[i] = m_ret[i] + 1;
      if (m_trig[i] < 0) begin
        inv = wb_valid[i] && !ok;
        to  = (tout_of(i) != 0) && (sat(i, e - 1) == tout_of(i) - 1);
        if (ext_halt[i] || inv || to) begin
          m_trig[i]  = e;
          m_cause[i] = ext_halt[i] ? 2'b11 : (inv ? 2'b01 : 2'b10);
        end
      end
    end
  endtask

  always @(posedge clk)
    for (int i = 0; i < N; i++)
      if (rst_n[i] === 1'b1) model_step(i);

  function automatic logic [67:0] get_exp(int i);
    logic st, hl;
    longint c, last;
    last = m_trig[i] + drain_of(i);
    st = (m_trig[i] >= 0);
    hl = st && (m_edges[i] >= last);
    c  = (st && m_edges[i] > last) ? last : m_edges[i];
    return {st, hl, m_cause[i], 32'(sat(i, c)), 32'(sat(i, m_ret[i]))};
  endfunction

  function automatic logic [67:0] get_obs(int i);
    case (i)
      0:       return {pc_stall[0], halted[0], cause[0], cyc0, ret0};
      1:       return {pc_stall[1], halted[1], cause[1], cyc1, ret1};
      default: return {pc_stall[2], halted[2], cause[2], 28'd0, cyc2, 28'd0, ret2};
    endcase
  endfunction

  task automatic drive(int i, logic v, logic [6:0] op, logic ext);
    wb_valid[i]  = v;
    wb_opcode[i] = op;
    ext_halt[i]  = ext;
  endtask

  task automatic do_reset_all();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      rst_n[i] = 1'b0;
      drive(i, 1'b0, 7'd0, 1'b0);
      model_reset(i);
    end
    @(negedge clk);
    for (int i = 0; i < N; i++) rst_n[i] = 1'b1;
  endtask

  task automatic test_reset();
    do_reset_all();
    for (int i = 0; i < N; i++) begin
      total++;
      if (get_obs(i) !== 68'd0)
        $display("FAIL reset inst%0d: got %h expected 0", i, get_obs(i));
      else passed++;
    end
  endtask

  task automatic test_invalid_opcode();
    do_reset_all();
    for (int k = 0; k < 15; k++) begin
      if (k < 10)       drive(0, 1'b1, 7'b0010011, 1'b0);
      else if (k == 10) drive(0, 1'b1, 7'b0000000, 1'b0);
      else              drive(0, 1'b0, 7'b0010011, 1'b0);
      @(negedge clk);
      total++;
      if (get_obs(0) !== get_exp(0))
        $display("FAIL invalid_op cycle%0d: got %h expected %h", k, get_obs(0), get_exp(0));
      else passed++;
      if (k == 10 || k == 13) begin
        total++;
        if ({pc_stall[0], halted[0]} !== {1'b1, k == 13})
          $display("FAIL invalid_op_stall cycle%0d: got %b%b expected 1%b", k, pc_stall[0], halted[0], k == 13);
        else passed++;
      end
    end
    total++;
    if ({cause[0], ret0} !== {2'b01, 32'd10})
      $display("FAIL invalid_op_final: got cause %b retire %0d expected cause 01 retire 10", cause[0], ret0);
    else passed++;
  endtask

  task automatic test_timeout();
    do_reset_all();
    drive(0, 1'b0, 7'd0, 1'b0);
    for (int k = 1; k <= 210; k++) begin
      @(negedge clk);
      total++;
      if (get_obs(0) !== get_exp(0))
        $display("FAIL timeout edge%0d: got %h expected %h", k, get_obs(0), get_exp(0));
      else passed++;
      if (k == 199 || k == 200 || k == 202 || k == 203) begin
        total++;
        if ({pc_stall[0], halted[0]} !== {k >= 200, k >= 203})
          $display("FAIL timeout_phase edge%0d: got %b%b expected %b%b", k, pc_stall[0], halted[0], k >= 200, k >= 203);
        else passed++;
      end
    end
    total++;
    if ({cause[0], cyc0} !== {2'b10, 32'd203})
      $display("FAIL timeout_final: got cause %b cycle %0d expected cause 10 cycle 203", cause[0], cyc0);
    else passed++;
  endtask

  task automatic test_priority();
    do_reset_all();
    for (int k = 0; k < 8; k++) begin
      if (k < 3)       drive(0, 1'b1, valid_ops[$urandom_range(0, 9)], 1'b0);
      else if (k == 3) drive(0, 1'b1, 7'b1111111, 1'b1);
      else if (k == 4) drive(0, 1'b1, 7'b0000000, 1'b0);
      else             drive(0, 1'b0, 7'd0, 1'b0);
      @(negedge clk);
      total++;
      if (get_obs(0) !== get_exp(0))
        $display("FAIL priority cycle%0d: got %h expected %h", k, get_obs(0), get_exp(0));
      else passed++;
    end
    total++;
    if ({halted[0], cause[0], ret0} !== {1'b1, 2'b11, 32'd3})
      $display("FAIL priority_final: got halted %b cause %b retire %0d expected 1 11 3", halted[0], cause[0], ret0);
    else passed++;
  endtask

  task automatic test_zero_drain();
    do_reset_all();
    drive(1, 1'b1, 7'b0110011, 1'b0);
    @(negedge clk);
    drive(1, 1'b0, 7'd0, 1'b1);
    @(negedge clk);
    drive(1, 1'b0, 7'd0, 1'b0);
    total++;
    if ({pc_stall[1], halted[1], cause[1]} !== 4'b1111)
      $display("FAIL zero_drain_edge: got %b%b%b expected 1111", pc_stall[1], halted[1], cause[1]);
    else passed++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (get_obs(1) !== get_exp(1))
        $display("FAIL zero_drain cycle%0d: got %h expected %h", k, get_obs(1), get_exp(1));
      else passed++;
    end
  endtask

  task automatic test_async_reset();
    do_reset_all();
    drive(0, 1'b0, 7'd0, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 7'd0, 1'b0);
    @(negedge clk);
    #2;
    rst_n[0] = 1'b0;
    model_reset(0);
    #1;
    total++;
    if (get_obs(0) !== 68'd0)
      $display("FAIL async_reset: got %h expected 0", get_obs(0));
    else passed++;
    @(negedge clk);
    rst_n[0] = 1'b1;
    drive(0, 1'b1, 7'b0010011, 1'b0);
    for (int k = 0; k < 5; k++) @(negedge clk);
    total++;
    if (get_obs(0) !== {4'b0000, 32'd5, 32'd5})
      $display("FAIL async_reset_resume: got %h expected cycle 5 retire 5", get_obs(0));
    else passed++;
  endtask

  task automatic test_saturation();
    do_reset_all();
    for (int k = 0; k < 20; k++) begin
      drive(2, 1'b1, valid_ops[$urandom_range(0, 9)], 1'b0);
      @(negedge clk);
      total++;
      if (get_obs(2) !== get_exp(2))
        $display("FAIL saturation cycle%0d: got %h expected %h", k, get_obs(2), get_exp(2));
      else passed++;
    end
    total++;
    if ({pc_stall[2], halted[2], cyc2, ret2} !== {2'b00, 4'd15, 4'd15})
      $display("FAIL saturation_final: got stall %b halted %b cycle %0d retire %0d expected 0 0 15 15",
               pc_stall[2], halted[2], cyc2, ret2);
    else passed++;
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      do_reset_all();
      for (int k = 0; k < 120; k++) begin
        for (int i = 0; i < N; i++)
          drive(i, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 99) < 90) ? valid_ops[$urandom_range(0, 9)] : 7'($urandom),
                $urandom_range(0, 99) < 2);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
          total++;
          if (get_obs(i) !== get_exp(i))
            $display("FAIL random inst%0d round%0d cycle%0d: got %h expected %h", i, r, k, get_obs(i), get_exp(i));
          else passed++;
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      rst_n[i] = 1'b0;
      drive(i, 1'b0, 7'd0, 1'b0);
      model_reset(i);
    end
    test_reset();
    test_invalid_opcode();
    test_timeout();
    test_priority();
    test_zero_drain();
    test_async_reset();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
